// File: rtl/stb_pkg.sv
// Shared STB types: drain FSM state encoding and default bus widths.
// Imported by the drain controller, the STB datapath and the LSU/STB controller.
package stb_pkg;

    localparam int STB_ADDR_W = 32;
    localparam int STB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2
    } drain_state_t;

endpackage

// File: rtl/stb_drain_ctrl_if.sv
// Single dcache port shared by LSU loads and STB drain writes.
// master: drives dc_req/dc_w_en/dc_addr/dc_wdata/dc_sel, samples dc2stb_ack.
// slave : the dcache side.
interface stb_drain_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  dc_req;
    logic                  dc_w_en;
    logic [ADDR_W-1:0]     dc_addr;
    logic [DATA_W-1:0]     dc_wdata;
    logic [DATA_W/8-1:0]   dc_sel;
    logic                  dc2stb_ack;

    modport master (
        output dc_req, dc_w_en, dc_addr, dc_wdata, dc_sel,
        input  dc2stb_ack
    );

    modport slave (
        input  dc_req, dc_w_en, dc_addr, dc_wdata, dc_sel,
        output dc2stb_ack
    );
endinterface

// File: rtl/stb_starve_cnt.sv
// Saturating count of loads granted while the STB waits to drain.
// Ports: clk, rst, inc_i (count up), clr_i (wins over inc), cnt_o, sat_o (cnt==MAX).
module stb_starve_cnt #(
    parameter  int MAX_LD_BURST = 4,
    localparam int CNT_W        = $clog2(MAX_LD_BURST + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             sat_o
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign sat_o = (cnt_q == CNT_W'(MAX_LD_BURST));
    assign cnt_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !sat_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/stb_drain_ctrl.sv
// Arbitrates the dcache port between LSU loads and STB drain writes; pops the STB on write ack.
// Ports: clk/rst, stb_* (STB head + status), lsummu* (load req/done), dc (dcache master),
//        fence_req/stb2lsummu_fence_done. Define STB_FLUSH_EN to enable the fence drain-all.
module stb_drain_ctrl
    import stb_pkg::*;
#(
    parameter int ADDR_W       = STB_ADDR_W,
    parameter int DATA_W       = STB_DATA_W,
    parameter int MAX_LD_BURST = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stb_empty,
    input  logic                stb_full,
    input  logic [ADDR_W-1:0]   stb_head_addr,
    input  logic [DATA_W-1:0]   stb_head_data,
    input  logic [DATA_W/8-1:0] stb_head_sel,
    output logic                stb_rd_en,
    input  logic                lsummu2dc_ld_req,
    input  logic [ADDR_W-1:0]   lsummu2dc_ld_addr,
    output logic                lsummu_ld_done,
    stb_drain_ctrl_if.master    dc,
    input  logic                fence_req,
    output logic                stb2lsummu_fence_done
);
    localparam int SEL_W = DATA_W / 8;
    localparam int CNT_W = $clog2(MAX_LD_BURST + 1);

    drain_state_t       state_q;
    logic               req_q;
    logic               wen_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [SEL_W-1:0]   sel_q;

    logic               fence_act;
    logic               starve_sat;
    logic [CNT_W-1:0]   starve_cnt;
    logic               drain_ok;
    logic               ld_ok;
    logic               ack_ld;
    logic               ack_st;

`ifdef STB_FLUSH_EN
    logic fence_pend_q;
    logic fence_pend_d;

    // The raw request also counts so a load can't slip in on the fence's first cycle.
    assign fence_act             = fence_pend_q | fence_req;
    assign stb2lsummu_fence_done = fence_pend_q & stb_empty & (state_q == IDLE);
    assign fence_pend_d          = stb2lsummu_fence_done ? 1'b0
                                 : (fence_pend_q | fence_req);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fence_pend_q <= 1'b0;
        end else begin
            fence_pend_q <= fence_pend_d;
        end
    end
`else
    logic unused_fence;

    assign unused_fence          = fence_req;
    assign fence_act             = 1'b0;
    assign stb2lsummu_fence_done = 1'b0;
`endif

    assign ack_ld = (state_q == LOAD)  & dc.dc2stb_ack;
    assign ack_st = (state_q == STORE) & dc.dc2stb_ack;

    // stb_full with stb_empty is illegal; letting full win keeps the drain path preferred.
    assign drain_ok = stb_full
                    | (!stb_empty & (fence_act | starve_sat | !lsummu2dc_ld_req));
    assign ld_ok    = lsummu2dc_ld_req & !fence_act;

    assign stb_rd_en      = ack_st;
    assign lsummu_ld_done = ack_ld;

    stb_starve_cnt #(
        .MAX_LD_BURST (MAX_LD_BURST)
    ) u_starve (
        .clk   (clk),
        .rst   (rst),
        .inc_i (ack_ld & !stb_empty),
        .clr_i (stb_empty | ack_st),
        .cnt_o (starve_cnt),
        .sat_o (starve_sat)
    );

    assign dc.dc_req   = req_q;
    assign dc.dc_w_en  = wen_q;
    assign dc.dc_addr  = addr_q;
    assign dc.dc_wdata = wdata_q;
    assign dc.dc_sel   = sel_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (drain_ok) begin
                        state_q <= STORE;
                        req_q   <= 1'b1;
                        wen_q   <= 1'b1;
                        addr_q  <= stb_head_addr;
                        wdata_q <= stb_head_data;
                        sel_q   <= stb_head_sel;
                    end else if (ld_ok) begin
                        state_q <= LOAD;
                        req_q   <= 1'b1;
                        wen_q   <= 1'b0;
                        addr_q  <= lsummu2dc_ld_addr;
                        wdata_q <= '0;
                        sel_q   <= '1;
                    end
                end
                LOAD, STORE: begin
                    if (dc.dc2stb_ack) begin
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end
endmodule
